// File: rtl/imem_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_loader
// Brief    : Boot loader that frames a byte stream into little-endian words,
//            writes instruction/data memory and gates the CPU reset.
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        mem_we_o,
    output logic        mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_rst_n_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_max = '1;

    state_t            r_state;
    logic              r_target;
    logic [6:0]        r_remaining;
    logic [ADDR_W-1:0] r_waddr;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;

    logic w_accept;
    assign w_accept = rx_valid_i & rx_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_target    <= 1'b0;
            r_remaining <= '0;
            r_waddr     <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            rx_ready_o  <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_sel_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            cpu_rst_n_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (rx_data_i == 8'h00) begin
                            cpu_rst_n_o <= 1'b1;
                            r_state     <= S_RUN;
                        end else if (rx_data_i[6:0] != 7'd0) begin
                            // A zero word count (0x80) is not a legal frame and is dropped.
                            r_target    <= rx_data_i[7];
                            r_remaining <= rx_data_i[6:0];
                            busy_o      <= 1'b1;
                            r_state     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        r_waddr    <= rx_data_i[ADDR_W-1:0];
                        r_byte_cnt <= '0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= {rx_data_i, r_word[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            mem_data_o <= {rx_data_i, r_word};
                            mem_addr_o <= {{(30-ADDR_W){1'b0}}, r_waddr, 2'b00};
                            mem_sel_o  <= r_target;
                            mem_we_o   <= 1'b1;
                            rx_ready_o <= 1'b0;
                            r_byte_cnt <= '0;
                            r_state    <= S_WRITE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_o    <= 1'b0;
                    rx_ready_o  <= 1'b1;
                    r_waddr     <= r_waddr + 1'b1;
                    r_remaining <= r_remaining - 7'd1;
                    // Flag only when a further word of this frame lands on a wrapped address.
                    if (r_waddr == c_addr_max && r_remaining != 7'd1) begin
                        err_o <= 1'b1;
                    end
                    if (r_remaining == 7'd1) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_RUN: begin
                    if (w_accept && rx_data_i == 8'h00) begin
                        cpu_rst_n_o <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_loader
// Brief    : Directed self-checking bench for imem_dmem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_loader;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // write log captured by the monitor
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic        wr_sel  [0:15];
    int          wr_cnt      = 0;
    int          we_bad      = 0;
    logic        prev_we     = 1'b0;
    logic        ready_after = 1'b0;

    imem_dmem_loader #(.ADDR_W(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .mem_we_o    (mem_we),
        .mem_sel_o   (mem_sel),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .cpu_rst_n_o (cpu_rst_n),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each pulse must be one cycle wide with rx_ready low, and ready back high the cycle after.
    always @(negedge clk) begin
        if (ready_after && !rx_ready) we_bad++;
        ready_after = 1'b0;
        if (mem_we) begin
            if (prev_we) we_bad++;
            if (rx_ready) we_bad++;
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_data;
                wr_sel[wr_cnt]  = mem_sel;
            end
            wr_cnt++;
            ready_after = 1'b1;
        end
        prev_we = mem_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check_eq("send_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input logic [7:0] bytes [], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq [];
        int base;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // reset held for two cycles
        repeat (2) @(negedge clk);
        check_eq("rst_ready",  {31'd0, rx_ready},  32'd1);
        check_eq("rst_we",     {31'd0, mem_we},    32'd0);
        check_eq("rst_sel",    {31'd0, mem_sel},   32'd0);
        check_eq("rst_addr",   mem_addr,           32'd0);
        check_eq("rst_data",   mem_data,           32'd0);
        check_eq("rst_cpu",    {31'd0, cpu_rst_n}, 32'd0);
        check_eq("rst_busy",   {31'd0, busy},      32'd0);
        check_eq("rst_err",    {31'd0, err},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, rx_ready},  32'd1);

        // instruction load, two words
        seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        base = wr_cnt;
        send_byte(seq[0]);
        send_byte(seq[1]);
        check_eq("busy_frame", {31'd0, busy}, 32'd1);
        for (int i = 2; i < 10; i++) send_byte(seq[i]);
        settle();
        check_eq("il_count", wr_cnt - base,          32'd2);
        check_eq("il_sel0",  {31'd0, wr_sel[base]},  32'd0);
        check_eq("il_addr0", wr_addr[base],          32'h0);
        check_eq("il_data0", wr_data[base],          32'h12345678);
        check_eq("il_addr1", wr_addr[base+1],        32'h4);
        check_eq("il_data1", wr_data[base+1],        32'hDEADBEEF);
        check_eq("il_busy",  {31'd0, busy},          32'd0);
        check_eq("il_err",   {31'd0, err},           32'd0);
        check_eq("il_cpu",   {31'd0, cpu_rst_n},     32'd0);

        // data load wrapping past the top word
        seq = '{8'h82, 8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        base = wr_cnt;
        send_seq(seq, 10);
        settle();
        check_eq("wr_count", wr_cnt - base,         32'd2);
        check_eq("wr_sel0",  {31'd0, wr_sel[base]}, 32'd1);
        check_eq("wr_addr0", wr_addr[base],         32'h7C);
        check_eq("wr_data0", wr_data[base],         32'h04030201);
        check_eq("wr_addr1", wr_addr[base+1],       32'h00);
        check_eq("wr_data1", wr_data[base+1],       32'h08070605);
        check_eq("wr_err",   {31'd0, err},          32'd1);

        // start, ignored byte, stop
        send_byte(8'h00);
        check_eq("start_cpu",  {31'd0, cpu_rst_n}, 32'd1);
        check_eq("start_err",  {31'd0, err},       32'd1);
        base = wr_cnt;
        send_byte(8'h55);
        send_byte(8'h03);
        settle();
        check_eq("run_ignore", {31'd0, cpu_rst_n}, 32'd1);
        check_eq("run_busy",   {31'd0, busy},      32'd0);
        send_byte(8'h00);
        check_eq("stop_cpu",   {31'd0, cpu_rst_n}, 32'd0);
        check_eq("stop_nowr",  wr_cnt - base,      32'd0);

        // stalled frame resumes to the same word
        base = wr_cnt;
        send_byte(8'h81);
        check_eq("new_frame_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (10) @(negedge clk);
        check_eq("stall_nowr", wr_cnt - base,      32'd0);
        check_eq("stall_busy", {31'd0, busy},      32'd1);
        send_byte(8'hCC);
        send_byte(8'hDD);
        settle();
        check_eq("stall_count", wr_cnt - base,         32'd1);
        check_eq("stall_sel",   {31'd0, wr_sel[base]}, 32'd1);
        check_eq("stall_addr",  wr_addr[base],         32'h14);
        check_eq("stall_data",  wr_data[base],         32'hDDCCBBAA);

        // reset in the middle of a word
        seq = '{8'h01, 8'h03, 8'h99, 8'h88, 8'h77};
        base = wr_cnt;
        send_seq(seq, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_we",   {31'd0, mem_we}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy},   32'd0);
        check_eq("mrst_err",  {31'd0, err},    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
        check_eq("mrst_nowr", wr_cnt - base, 32'd0);
        seq = '{8'h01, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(seq, 6);
        settle();
        check_eq("post_count", wr_cnt - base,         32'd1);
        check_eq("post_sel",   {31'd0, wr_sel[base]}, 32'd0);
        check_eq("post_addr",  wr_addr[base],         32'h28);
        check_eq("post_data",  wr_data[base],         32'h44332211);

        check_eq("we_protocol", we_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
